// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared constants and helpers for the instruction prefetch buffer.
package instr_prefetch_buffer_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [ADDR_W-1:0] WORD_STRIDE      = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_chk.sv
// Run-time checks on the prefetch buffer's credit bookkeeping.
module instr_prefetch_buffer_chk #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic [CNT_W-1:0] occ,
  input logic [CNT_W-1:0] outstanding
);

  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  // A response must never land in a full FIFO unless the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

  // Buffered plus in-flight fetches never exceed the FIFO capacity.
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    (({1'b0, occ} + {1'b0, outstanding}) <= DEPTH_LIM));

endmodule

// File: rtl/prefetch_fifo.sv
// Show-ahead FIFO with synchronous clear and occupancy output.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [CNT_W-1:0] occ
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] occ_r;
  logic [CNT_W-1:0] occ_next_s;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;

  assign full_s    = (occ_r == FULL_CNT);
  assign do_pop_s  = pop && (occ_r != '0);
  assign do_push_s = push && (!full_s || do_pop_s);

  // Occupancy update for the simultaneous push/pop combinations.
  always_comb begin
    occ_next_s = occ_r;
    case ({do_push_s, do_pop_s})
      2'b10:   occ_next_s = occ_r + CNT_W'(1);
      2'b01:   occ_next_s = occ_r - CNT_W'(1);
      default: occ_next_s = occ_r;
    endcase
  end

  // Pointer and occupancy registers; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      occ_r <= occ_next_s;
    end
  end

  // Storage; zeroed on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data  = mem_r[rd_ptr_r];
  assign head_valid = (occ_r != '0);
  assign full       = full_s;
  assign occ        = occ_r;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch stage: sequential fetch issue, in-order response
// buffering and redirect flushing with stale-response drop counting.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int             CNT_W     = $clog2(DEPTH + 1);
  localparam int             ENTRY_W   = ADDR_W + INSTR_W;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  rsp_pc_r;
  logic [CNT_W-1:0]   outstanding_r;
  logic [CNT_W-1:0]   drop_r;
  logic [CNT_W-1:0]   outstanding_next_s;
  logic [CNT_W-1:0]   drop_next_s;
  logic [CNT_W-1:0]   occ_s;
  logic               fifo_full_s;
  logic               head_valid_s;
  logic [ENTRY_W-1:0] head_data_s;
  logic               credit_s;
  logic               req_valid_s;
  logic               req_fire_s;
  logic               rsp_fire_s;
  logic               keep_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  target_s;

  assign target_s    = word_align(redirect_pc);
  assign credit_s    = (({1'b0, occ_s} + {1'b0, outstanding_r}) < DEPTH_LIM);
  assign req_valid_s = reset && !redirect && credit_s;
  assign req_fire_s  = req_valid_s && imem_req_ready;
  // A response with nothing outstanding is stale (e.g. from before reset).
  assign rsp_fire_s  = imem_rsp_valid && (outstanding_r != '0);
  assign keep_s      = rsp_fire_s && (drop_r == '0) && !redirect;
  assign pop_s       = instr_ready && !redirect;

  // In-flight counter: +1 per accepted request, -1 per retired response.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({req_fire_s, rsp_fire_s})
      2'b10:   outstanding_next_s = outstanding_r + CNT_W'(1);
      2'b01:   outstanding_next_s = outstanding_r - CNT_W'(1);
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // Drop counter: a redirect marks every still-pending response as stale.
  always_comb begin
    drop_next_s = drop_r;
    if (redirect) begin
      drop_next_s = outstanding_r - CNT_W'(rsp_fire_s);
    end else if (rsp_fire_s && (drop_r != '0)) begin
      drop_next_s = drop_r - CNT_W'(1);
    end else begin
      drop_next_s = drop_r;
    end
  end

  // Fetch address, response address tracker and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
    end else begin
      outstanding_r <= outstanding_next_s;
      drop_r        <= drop_next_s;
      if (redirect) begin
        fetch_pc_r <= target_s;
        rsp_pc_r   <= target_s;
      end else begin
        if (req_fire_s) fetch_pc_r <= fetch_pc_r + WORD_STRIDE;
        if (keep_s)     rsp_pc_r   <= rsp_pc_r + WORD_STRIDE;
      end
    end
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (redirect),
    .push       (keep_s),
    .push_data  ({rsp_pc_r, imem_rsp_data}),
    .pop        (pop_s),
    .head_data  (head_data_s),
    .head_valid (head_valid_s),
    .full       (fifo_full_s),
    .occ        (occ_s)
  );

  instr_prefetch_buffer_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk         (clk),
    .rst_n       (reset),
    .push        (keep_s),
    .pop         (pop_s),
    .full        (fifo_full_s),
    .occ         (occ_s),
    .outstanding (outstanding_r)
  );

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign instr_valid    = head_valid_s;
  assign instr          = head_data_s[INSTR_W-1:0];
  assign instr_pc       = head_data_s[ENTRY_W-1:INSTR_W];

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a latency-modelled memory plus a
// scoreboard of the instruction stream the datapath should observe.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  typedef struct { logic [31:0] addr; int epoch; int rdy; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        mq[$];      // requests accepted by memory, awaiting response
  ent_t        bq[$];      // instructions the datapath should see, in order
  int          checks = 0;
  int          errors = 0;
  int          t = 0;
  int          epoch = 0;
  int          rsp_prob = 100;
  bit          ghost_pending = 1'b0;
  logic [31:0] exp_req_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy_in,
                      input bit reqrdy, input int lat);
    bit          rv;
    bit          exp_rv;
    bit          has_head;
    bit          keep;
    logic [31:0] rd;
    req_t        e;
    ent_t        n;
    rv = 1'b0; rd = 32'h0; keep = 1'b0; n.pc = 32'h0; n.data = 32'h0;
    if (ghost_pending) begin
      rv = 1'b1; rd = 32'hDEAD_BEEF;
    end else if (mq.size() > 0) begin
      if (mq[0].rdy <= t && $urandom_range(99) < rsp_prob) begin
        rv = 1'b1; rd = mem_word(mq[0].addr);
      end
    end
    redirect = redir; redirect_pc = rpc; instr_ready = rdy_in;
    imem_req_ready = reqrdy; imem_rsp_valid = rv; imem_rsp_data = rd;
    #1;
    exp_rv = !redir && ((bq.size() + mq.size()) < DEPTH);
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, exp_req_pc);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, bq.size() > 0});
    if (bq.size() > 0) begin
      check("instr", instr, bq[0].data);
      check("instr_pc", instr_pc, bq[0].pc);
    end
    if (exp_rv && reqrdy) begin
      e.addr = exp_req_pc; e.epoch = epoch; e.rdy = t + lat;
      mq.push_back(e);
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (ghost_pending) begin
      ghost_pending = 1'b0;
    end else if (rv) begin
      e = mq.pop_front();
      keep = (e.epoch == epoch) && !redir;
      n.pc = e.addr; n.data = mem_word(e.addr);
    end
    has_head = bq.size() > 0;
    if (redir) begin
      bq.delete();
      epoch++;
      exp_req_pc = {rpc[31:2], 2'b00};
    end else begin
      if (rdy_in && has_head) bq.delete(0);
      if (keep) bq.push_back(n);
    end
    @(posedge clk); t++; @(negedge clk);
  endtask

  // Assert reset mid-cycle, hold it n cycles with stale responses arriving, release.
  task automatic reset_phase(input int n);
    ghost_pending = (mq.size() > 0);
    mq.delete(); bq.delete();
    redirect = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; redirect_pc = 32'h0;
    #1 reset = 1'b0;
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    for (int i = 0; i < n; i++) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000 + i;
      @(posedge clk); t++; @(negedge clk); #1;
      check("rst_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_hold_instr_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;
    reset = 1'b1;
    epoch++;
    exp_req_pc = RESET_PC;
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(negedge clk);
    reset_phase(3);

    // Streaming with a 1-cycle memory and an always-ready datapath.
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Redirect coinciding with a pop and an arriving response.
    step(1'b1, 32'h0040_0200, 1'b1, 1'b1, 1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Stalled datapath: credit caps fetches at DEPTH, one pop frees one slot.
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1);

    // Latency 3, redirect to a misaligned target with fetches in flight.
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 32'h0040_0103, 1'b1, 1'b1, 3);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 3);

    // Address wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Back-to-back redirects under latency 3.
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 32'h0000_1000, 1'b0, 1'b1, 3);
    step(1'b1, 32'h0000_2002, 1'b1, 1'b1, 3);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 3);

    // Reset mid-stream with fetches outstanding.
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
    reset_phase(2);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 2);

    // Randomised traffic.
    rsp_prob = 70;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else tgt = $urandom;
      step($urandom_range(99) < 6, tgt, $urandom_range(99) < 70,
           $urandom_range(99) < 75, $urandom_range(4, 1));
    end
    rsp_prob = 100;
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
